// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready requesters
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid_i       per-requester word valid
//   req_data_i        packed payloads, requester i at [i*WIDTH +: WIDTH]
//   req_ready_o       one-hot grant, word i accepted when valid & ready
//   fifo_full_i       FIFO full flag
//   fifo_wr_en_o      FIFO write strobe
//   fifo_wr_data_o    {source id, payload} from the output register
//   busy_o            output stage holds a word
// Optional FIFO_ARB_GRANT_CNT_EN adds cnt_clr_i and grant_cnt_o (saturating per-requester handshake counts).
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
`ifdef FIFO_ARB_GRANT_CNT_EN
  ,
  parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0]    req_data_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic                        fifo_full_i,
  output logic                        fifo_wr_en_o,
  output logic [WIDTH+ID_WIDTH-1:0]   fifo_wr_data_o,
  output logic                        busy_o
`ifdef FIFO_ARB_GRANT_CNT_EN
  ,
  input  logic                        cnt_clr_i,
  output logic [NUM_REQ*CNT_WIDTH-1:0] grant_cnt_o
`endif
);
  logic                      out_valid_q, out_valid_d;
  logic [WIDTH+ID_WIDTH-1:0] out_data_q, out_data_d;
  logic [ID_WIDTH-1:0]       last_grant_q, last_grant_d;
  logic [ID_WIDTH-1:0]       winner, idx;
  logic                      found, hs;
  assign fifo_wr_en_o   = out_valid_q & ~fifo_full_i;
  assign fifo_wr_data_o = out_data_q;
  assign busy_o         = out_valid_q;
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_WIDTH'((int'(last_grant_q) + k) % NUM_REQ);
      if (!found && req_valid_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end
  // A full FIFO freezes arbitration even when the stage is empty; rst_n gates grants so they read 0 in reset.
  assign req_ready_o = (found & ~fifo_full_i & rst_n) ? NUM_REQ'(1) << winner : '0;
  assign hs          = |req_ready_o;
  always_comb begin
    out_valid_d  = hs ? 1'b1 : (fifo_wr_en_o ? 1'b0 : out_valid_q);
    out_data_d   = hs ? {winner, req_data_i[int'(winner)*WIDTH +: WIDTH]} : out_data_q;
    last_grant_d = hs ? winner : last_grant_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      last_grant_q <= last_grant_d;
    end
  end
`ifdef FIFO_ARB_GRANT_CNT_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    always_comb cnt_d = cnt_clr_i ? '0 : ((req_ready_o[g] & req_valid_i[g] & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
    end
    assign grant_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized and directed bench checking fifo_wr_arbiter against a behavioural model
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int W = 8;
  localparam int IDW = 2;
  localparam int DW = W + IDW;
`ifdef FIFO_ARB_GRANT_CNT_EN
  localparam int CW = 4;
  logic cnt_clr = 1'b0;
  logic [NR*CW-1:0] grant_cnt;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR*W-1:0] req_data = '0;
  logic fifo_full = 1'b0;
  logic [NR-1:0] req_ready;
  logic fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic busy;
  int n_chk = 0;
  int n_pass = 0;
  fifo_wr_arbiter #(
    .NUM_REQ(NR),
    .WIDTH(W)
`ifdef FIFO_ARB_GRANT_CNT_EN
    ,
    .CNT_WIDTH(CW)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid_i(req_valid),
    .req_data_i(req_data),
    .req_ready_o(req_ready),
    .fifo_full_i(fifo_full),
    .fifo_wr_en_o(fifo_wr_en),
    .fifo_wr_data_o(fifo_wr_data),
    .busy_o(busy)
`ifdef FIFO_ARB_GRANT_CNT_EN
    ,
    .cnt_clr_i(cnt_clr),
    .grant_cnt_o(grant_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask
  // Behavioural model: a staged word, the last granted index and a queue of words owed to the FIFO.
  bit m_valid;
  logic [DW-1:0] m_data;
  int m_last = NR - 1;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] wr_log[$];
  logic [NR-1:0] hs_vec = '0;
  int waitc[NR];
  int w;
  logic [NR-1:0] er;
  bit ew;
  logic [DW-1:0] exp_w;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wr_data", fifo_wr_data, 0);
      m_valid = 0;
      m_data = '0;
      m_last = NR - 1;
      sb.delete();
      hs_vec = '0;
      for (int i = 0; i < NR; i++) waitc[i] = 0;
    end else begin
      w = -1;
      for (int k = 1; k <= NR; k++) if (w < 0 && req_valid[(m_last + k) % NR]) w = (m_last + k) % NR;
      er = (w >= 0 && !fifo_full) ? NR'(1) << w : '0;
      ew = m_valid && !fifo_full;
      chk("req_ready", req_ready, er);
      chk("wr_en", fifo_wr_en, ew);
      chk("wr_data", fifo_wr_data, m_data);
      chk("busy", busy, m_valid);
      if (ew) begin
        exp_w = sb.size() > 0 ? sb.pop_front() : 'x;
        chk("sb_order", fifo_wr_data, exp_w);
        wr_log.push_back(fifo_wr_data);
      end
      hs_vec = req_ready & req_valid;
      if (hs_vec != 0)
        for (int i = 0; i < NR; i++) begin
          if (hs_vec[i]) waitc[i] = 0;
          else if (req_valid[i]) begin
            waitc[i]++;
            chk("fair_wait", waitc[i] <= NR - 1, 1);
          end
        end
      for (int i = 0; i < NR; i++) if (!req_valid[i]) waitc[i] = 0;
      if (er != 0) begin
        m_data = {IDW'(w), req_data[w*W +: W]};
        m_valid = 1;
        m_last = w;
        sb.push_back(m_data);
      end else if (ew) m_valid = 0;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic all_valid();
    req_valid = '1;
    for (int i = 0; i < NR; i++) req_data[i*W +: W] = W'(8'h10 + i);
  endtask
  task automatic drain();
    req_valid = '0;
    fifo_full = 0;
    repeat (3) step();
    wr_log.delete();
  endtask
  initial begin
    all_valid();
    repeat (2) step();
    rst_n = 1;
    wr_log.delete();
    repeat (7) step();
    chk("t1_w0", wr_log[0], 10'h010);
    chk("t1_w1", wr_log[1], 10'h111);
    chk("t1_w2", wr_log[2], 10'h212);
    chk("t1_w3", wr_log[3], 10'h313);
    chk("t1_w4", wr_log[4], 10'h010);
    drain();
    req_valid = 4'b0100;
    req_data[2*W +: W] = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t2_ready", req_ready, 4'b0100);
      step();
    end
    req_valid = '0;
    repeat (2) step();
    chk("t2_count", wr_log.size(), 5);
    for (int i = 0; i < 5; i++) chk("t2_word", wr_log[i], 10'h2A5);
    drain();
    req_valid = 4'b0010;
    req_data[1*W +: W] = 8'h3C;
    step();
    fifo_full = 1;
    all_valid();
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_wr_en", fifo_wr_en, 0);
      chk("t3_data", fifo_wr_data, 10'h13C);
      chk("t3_ready", req_ready, 0);
      step();
    end
    wr_log.delete();
    fifo_full = 0;
    #1 chk("t3_ready_after", req_ready, 4'b0100);
    repeat (2) step();
    chk("t3_first", wr_log[0], 10'h13C);
    chk("t3_second", wr_log[1], 10'h212);
    repeat (3) step();
    @(posedge clk);
    #2 chk("t4_busy_pre", busy, 1);
    #1 rst_n = 0;
    #1 chk("t4_wr_en", fifo_wr_en, 0);
    chk("t4_busy", busy, 0);
    chk("t4_ready", req_ready, 0);
    repeat (2) step();
    rst_n = 1;
    wr_log.delete();
    repeat (3) step();
    chk("t4_first", wr_log[0], 10'h010);
    req_valid = '0;
    step();
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < NR; i += 3)
        if (hs_vec[i] || !req_valid[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_data[i*W +: W] = W'($urandom);
        end
      req_valid[1] = 0;
      req_valid[2] = 0;
      fifo_full = $urandom_range(0, 3) == 0;
      step();
    end
    drain();
    chk("t5_sb_empty", sb.size(), 0);
`ifdef FIFO_ARB_GRANT_CNT_EN
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    chk("t6_clr0", grant_cnt[1*CW +: CW], 0);
    req_valid = 4'b0010;
    repeat (20) step();
    req_valid = '0;
    chk("t6_sat", grant_cnt[1*CW +: CW], 4'hF);
    chk("t6_other", grant_cnt[0 +: CW], 0);
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    chk("t6_clr", grant_cnt[1*CW +: CW], 0);
    drain();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
